prod_seq_engine: RTL and testbench

- Parametrised multi-pair multiply sequencer; successor to the fixed 8-bit MSW/LSW product path in the top level.
- Reads operand pairs from data memory, computes full 2*DW-bit unsigned products with a shift-add core, and writes MSW then LSW back to data memory.
- Sits beside data_mem as a memory-port master and reports a halt flag plus a cycle count.

---
 rtl/prod_pkg.sv | 28 ++
 rtl/shift_add_core.sv | 58 +++++
 rtl/prod_seq_engine.sv | 194 +++++++++++++++++++
 tb/tb_prod_seq_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prod_pkg.sv
// prod_pkg: shared FSM encoding and constants for the multi-pair product sequencer.
// Contents: state_t (3-bit, 8 states), CW_DEFAULT (cycle counter width), PAIR_LAT() (cycles per pair).
// Build option PROD_SIGNED_EN: adds the two's-complement negate cycle, so PAIR_LAT grows by one.
package prod_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    LATCH_B = 3'd3,
    MUL     = 3'd4,
    WR_HI   = 3'd5,
    WR_LO   = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int CW_DEFAULT = 16;

  // Cycles one operand pair occupies: 2 fetch, 1 latch, dw multiply steps, 2 writes.
  function automatic int PAIR_LAT(input int dw);
`ifdef PROD_SIGNED_EN
    return dw + 6;
`else
    return dw + 5;
`endif
  endfunction

endpackage

// File: rtl/shift_add_core.sv
// shift_add_core: unsigned DW x DW -> 2*DW shift-add multiplier, one partial product per step.
// Latency: load, then DW step cycles; done is high during the final step (product valid next cycle).
// Ports: CLK, start (async reset), load/a/b, step, [neg with PROD_SIGNED_EN], product, done. No backpressure.
module shift_add_core
  import prod_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic            CLK,
  input  logic            start,
  input  logic            load,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic            step,
`ifdef PROD_SIGNED_EN
  input  logic            neg,
`endif
  output logic [2*DW-1:0] product,
  output logic            done
);

  localparam int CNTW = $clog2(DW + 1);

  logic [2*DW-1:0] p_q, p_d;
  logic [DW-1:0]   m_q;
  logic [CNTW-1:0] cnt_q;
  logic [DW:0]     sum_d;   // {carry, new high half}

  // Multiplier bits are consumed from P[0]; the product grows in from the top.
  always_comb begin
    sum_d = {1'b0, p_q[2*DW-1:DW]};
    if (p_q[0]) sum_d = sum_d + {1'b0, m_q};
    p_d = {sum_d, p_q[DW-1:1]};
  end

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      p_q   <= '0;
      m_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      p_q   <= {{DW{1'b0}}, b};
      m_q   <= a;
      cnt_q <= '0;
    end else if (step) begin
      p_q   <= p_d;
      cnt_q <= cnt_q + CNTW'(1);
`ifdef PROD_SIGNED_EN
    end else if (neg) begin
      p_q   <= ~p_q + (2*DW)'(1);
`endif
    end
  end

  assign product = p_q;
  assign done    = step & (cnt_q == CNTW'(DW - 1));

endmodule

// File: rtl/prod_seq_engine.sv
// prod_seq_engine: reads operand pairs from data memory, multiplies them, writes MSW then LSW back.
// Latency: PAIR_LAT(DW) cycles per pair; go is only accepted in IDLE/DONE, ignored while busy.
// Ports: CLK, start (async reset), go/num_pairs, memory master port, busy/halt/cycle_ct status.
// Build option PROD_SIGNED_EN: adds signed_mode input (two's-complement operands, one extra cycle per pair).
module prod_seq_engine
  import prod_pkg::*;
#(
  parameter int DW       = 8,
  parameter int AW       = 8,
  parameter int PW       = 4,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 64,
  parameter int CW       = CW_DEFAULT
) (
  input  logic          CLK,
  input  logic          start,
  input  logic          go,
  input  logic [PW-1:0] num_pairs,
`ifdef PROD_SIGNED_EN
  input  logic          signed_mode,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          halt,
  output logic [CW-1:0] cycle_ct
);

  localparam logic [AW-1:0] SRC_A = AW'(SRC_BASE);
  localparam logic [AW-1:0] DST_A = AW'(DST_BASE);

  state_t          state_q;
  logic [PW-1:0]   np_q, idx_q;
  logic [PW:0]     idx_inc_d;
  logic [AW-1:0]   off_d, nxt_off_d;
  logic [DW-1:0]   a_q;
  logic [AW-1:0]   addr_q;
  logic            rd_q, wr_q, hi_sel_q, busy_q, halt_q;
  logic [CW-1:0]   cyc_q;
  logic            core_load, core_step, core_done;
  logic [2*DW-1:0] core_p;
  logic [DW-1:0]   a_mag_d, b_mag_d;

  assign idx_inc_d = {1'b0, idx_q} + (PW+1)'(1);
  assign off_d     = AW'({idx_q, 1'b0});               // 2*i, wraps modulo 2^AW
  assign nxt_off_d = AW'({idx_inc_d[PW-1:0], 1'b0});   // 2*(i+1)

`ifdef PROD_SIGNED_EN
  logic smode_q, sign_q, neg_ph_q, core_neg;
  // Magnitudes are formed DW+1 wide so the most-negative value maps to 2^(DW-1).
  assign a_mag_d   = (smode_q && a_q[DW-1])
                   ? DW'((DW+1)'(0) - {a_q[DW-1], a_q}) : a_q;
  assign b_mag_d   = (smode_q && mem_rdata[DW-1])
                   ? DW'((DW+1)'(0) - {mem_rdata[DW-1], mem_rdata}) : mem_rdata;
  assign core_step = (state_q == MUL) && !neg_ph_q;
  assign core_neg  = (state_q == MUL) && neg_ph_q && sign_q;
`else
  assign a_mag_d   = a_q;
  assign b_mag_d   = mem_rdata;
  assign core_step = (state_q == MUL);
`endif
  assign core_load = (state_q == LATCH_B);

  shift_add_core #(.DW(DW)) u_core (
    .CLK     (CLK),
    .start   (start),
    .load    (core_load),
    .a       (a_mag_d),
    .b       (b_mag_d),
    .step    (core_step),
`ifdef PROD_SIGNED_EN
    .neg     (core_neg),
`endif
    .product (core_p),
    .done    (core_done)
  );

  always_ff @(posedge CLK or posedge start) begin
    if (start) begin
      state_q  <= IDLE;
      np_q     <= '0;
      idx_q    <= '0;
      a_q      <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      hi_sel_q <= 1'b0;
      busy_q   <= 1'b0;
      halt_q   <= 1'b0;
      cyc_q    <= '0;
`ifdef PROD_SIGNED_EN
      smode_q  <= 1'b0;
      sign_q   <= 1'b0;
      neg_ph_q <= 1'b0;
`endif
    end else begin
      // Strobes and address are single-cycle; each state re-arms what the next state needs.
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      if (busy_q && cyc_q != '1) cyc_q <= cyc_q + CW'(1);

      case (state_q)
        IDLE, DONE: begin
          if (go) begin
            cyc_q <= '0;
            if (num_pairs != '0) begin
              np_q    <= num_pairs;
              idx_q   <= '0;
              halt_q  <= 1'b0;
              busy_q  <= 1'b1;
              rd_q    <= 1'b1;
              addr_q  <= SRC_A;
              state_q <= FETCH_A;
`ifdef PROD_SIGNED_EN
              smode_q <= signed_mode;
`endif
            end else begin
              halt_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        FETCH_A: begin
          rd_q    <= 1'b1;
          addr_q  <= SRC_A + off_d + AW'(1);
          state_q <= FETCH_B;
        end
        FETCH_B: begin
          a_q     <= mem_rdata;   // data for the FETCH_A read
          state_q <= LATCH_B;
        end
        LATCH_B: begin
`ifdef PROD_SIGNED_EN
          sign_q  <= smode_q & (a_q[DW-1] ^ mem_rdata[DW-1]);
`endif
          state_q <= MUL;
        end
        MUL: begin
`ifdef PROD_SIGNED_EN
          if (neg_ph_q) begin
            neg_ph_q <= 1'b0;
            wr_q     <= 1'b1;
            hi_sel_q <= 1'b1;
            addr_q   <= DST_A + off_d;
            state_q  <= WR_HI;
          end else if (core_done) begin
            neg_ph_q <= 1'b1;
          end
`else
          if (core_done) begin
            wr_q     <= 1'b1;
            hi_sel_q <= 1'b1;
            addr_q   <= DST_A + off_d;
            state_q  <= WR_HI;
          end
`endif
        end
        WR_HI: begin
          wr_q     <= 1'b1;
          hi_sel_q <= 1'b0;
          addr_q   <= DST_A + off_d + AW'(1);
          state_q  <= WR_LO;
        end
        WR_LO: begin
          idx_q <= idx_inc_d[PW-1:0];
          if (idx_inc_d == {1'b0, np_q}) begin
            halt_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            rd_q    <= 1'b1;
            addr_q  <= SRC_A + nxt_off_d;
            state_q <= FETCH_A;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Product is frozen during the write states, so the data mux needs no extra register.
  assign mem_wdata = wr_q ? (hi_sel_q ? core_p[2*DW-1:DW] : core_p[DW-1:0]) : '0;
  assign mem_addr  = addr_q;
  assign mem_rd_en = rd_q;
  assign mem_wr_en = wr_q;
  assign busy      = busy_q;
  assign halt      = halt_q;
  assign cycle_ct  = cyc_q;

endmodule

// File: tb/tb_prod_seq_engine.sv
// tb_prod_seq_engine: drives prod_seq_engine against a behavioural memory and product model.
// Expected products come from integer arithmetic on the bench's memory image; expected
// access order and run length come from the pair/address rules.
module tb_prod_seq_engine;

  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int PW  = 4;
  localparam int CW  = 16;
  localparam int SRC = 0;
  localparam int DST = 64;
`ifdef PROD_SIGNED_EN
  localparam int LAT = DW + 6;
`else
  localparam int LAT = DW + 5;
`endif

  logic          CLK = 1'b0;
  logic          start, go;
  logic [PW-1:0] num_pairs;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy, halt;
  logic [CW-1:0] cycle_ct;
  bit            smode = 1'b0;

  logic [DW-1:0] mem      [0:(1<<AW)-1];
  logic [DW-1:0] init_mem [0:(1<<AW)-1];
  logic          load_req = 1'b0;
  logic [AW:0]   trace[$];   // {is_write, addr} for every strobe seen
  int            viol = 0;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 CLK = ~CLK;

  prod_seq_engine #(
    .DW(DW), .AW(AW), .PW(PW), .SRC_BASE(SRC), .DST_BASE(DST), .CW(CW)
  ) dut (
    .CLK       (CLK),
    .start     (start),
    .go        (go),
    .num_pairs (num_pairs),
`ifdef PROD_SIGNED_EN
    .signed_mode (smode),
`endif
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .halt      (halt),
    .cycle_ct  (cycle_ct)
  );

  // Synchronous data memory with 1-cycle read latency; image reload on request.
  always @(posedge CLK) begin
    if (load_req) begin
      mem = init_mem;
    end else begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      if (mem_wr_en) mem[mem_addr] = mem_wdata;
    end
  end

  // Mid-cycle observation of the memory port.
  always @(negedge CLK) begin
    if (mem_rd_en && mem_wr_en) viol++;
    if (!busy && (mem_rd_en || mem_wr_en || mem_addr != '0 || mem_wdata != '0)) viol++;
    if (mem_rd_en || mem_wr_en) trace.push_back({mem_wr_en, mem_addr});
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sval(input int v);
    if (smode && v >= (1 << (DW - 1))) return v - (1 << DW);
    return v;
  endfunction

  function automatic int model_prod(input int i);
    int a, b;
    a = int'(mem[(SRC + 2*i) % (1 << AW)]);
    b = int'(mem[(SRC + 2*i + 1) % (1 << AW)]);
    return (sval(a) * sval(b)) & ((1 << (2*DW)) - 1);
  endfunction

  task automatic load_mem();
    load_req = 1'b1;
    @(negedge CLK);
    load_req = 1'b0;
  endtask

  // Launch a run of n pairs; if poke >= 0, pulse go with num_pairs=5 twice while busy.
  task automatic run_pairs(input string tag, input int n, input int poke);
    int cyc, base, bad, p, exp_e, idx;
    base = trace.size();
    @(negedge CLK);
    num_pairs = PW'(n);
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    cyc = 0;
    while (!halt && cyc < 5000) begin
      cyc++;
      go = (poke >= 0) && (cyc == poke || cyc == poke + 9);
      if (go) num_pairs = PW'(5);
      @(negedge CLK);
    end
    go = 1'b0;
    check_val({tag, ".busy_cycles"}, cyc, n * LAT);
    check_val({tag, ".cycle_ct"}, 32'(cycle_ct), n * LAT);
    check_val({tag, ".halt"}, 32'(halt), 1);
    check_val({tag, ".busy"}, 32'(busy), 0);
    for (int i = 0; i < n; i++) begin
      p = model_prod(i);
      check_val($sformatf("%s.msw%0d", tag, i), 32'(mem[(DST + 2*i) % (1 << AW)]), p >> DW);
      check_val($sformatf("%s.lsw%0d", tag, i), 32'(mem[(DST + 2*i + 1) % (1 << AW)]),
                p & ((1 << DW) - 1));
    end
    check_val({tag, ".access_count"}, trace.size() - base, 4 * n);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (k < 2) exp_e = (SRC + 2*i + k) % (1 << AW);
        else       exp_e = (1 << AW) | ((DST + 2*i + k - 2) % (1 << AW));
        idx = base + 4*i + k;
        if (idx >= trace.size() || int'(trace[idx]) != exp_e) bad++;
      end
    end
    check_val({tag, ".access_order_bad"}, bad, 0);
  endtask

  initial begin
    int base, p0;
    start = 1'b1;
    go = 1'b0;
    num_pairs = '0;
    for (int i = 0; i < (1 << AW); i++) init_mem[i] = '0;
    load_mem();
    repeat (2) @(negedge CLK);

    check_val("rst.addr",     32'(mem_addr), 0);
    check_val("rst.rd_en",    32'(mem_rd_en), 0);
    check_val("rst.wr_en",    32'(mem_wr_en), 0);
    check_val("rst.wdata",    32'(mem_wdata), 0);
    check_val("rst.busy",     32'(busy), 0);
    check_val("rst.halt",     32'(halt), 0);
    check_val("rst.cycle_ct", 32'(cycle_ct), 0);
    start = 1'b0;
    @(negedge CLK);

    // Zero pairs from IDLE: halt next cycle, no memory traffic.
    run_pairs("zero", 0, -1);

    // 0xFF * 0xFF
    init_mem = mem;
    init_mem[0] = 8'hFF;
    init_mem[1] = 8'hFF;
    load_mem();
    run_pairs("ffff", 1, -1);
    check_val("ffff.msw_const", 32'(mem[64]), 32'h FE);
    check_val("ffff.lsw_const", 32'(mem[65]), 32'h01);

    // Three directed pairs.
    init_mem = mem;
    init_mem[0] = 8'h03; init_mem[1] = 8'h07;
    init_mem[2] = 8'h00; init_mem[3] = 8'hAB;
    init_mem[4] = 8'h80; init_mem[5] = 8'h02;
    load_mem();
    run_pairs("three", 3, -1);
    check_val("three.m65", 32'(mem[65]), 32'h15);
    check_val("three.m68", 32'(mem[68]), 32'h01);

    // go while busy is ignored: exactly 2 pairs, then a go from DONE restarts the counter.
    run_pairs("gobusy", 2, 3);
    run_pairs("restart", 1, -1);

    // Randomized runs.
    for (int r = 0; r < 6; r++) begin
      init_mem = mem;
      for (int i = 0; i < 32; i++) init_mem[SRC + i] = DW'($urandom);
`ifdef PROD_SIGNED_EN
      smode = 1'($urandom_range(0, 1));
`endif
      load_mem();
      run_pairs($sformatf("rnd%0d", r), $urandom_range(1, 15), -1);
    end
    smode = 1'b0;

    // Reset during the multiply of the second pair.
    init_mem = mem;
    for (int i = 0; i < 6; i++) init_mem[SRC + i] = DW'($urandom);
    init_mem[66] = 8'h5A;
    init_mem[67] = 8'hA5;
    load_mem();
    @(negedge CLK);
    num_pairs = PW'(3);
    go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    repeat (17) @(negedge CLK);
    #2 start = 1'b1;
    #1;
    check_val("midrst.addr",     32'(mem_addr), 0);
    check_val("midrst.rd_en",    32'(mem_rd_en), 0);
    check_val("midrst.wr_en",    32'(mem_wr_en), 0);
    check_val("midrst.wdata",    32'(mem_wdata), 0);
    check_val("midrst.busy",     32'(busy), 0);
    check_val("midrst.halt",     32'(halt), 0);
    check_val("midrst.cycle_ct", 32'(cycle_ct), 0);
    @(negedge CLK);
    start = 1'b0;
    base = trace.size();
    repeat (8) @(negedge CLK);
    check_val("midrst.no_access", trace.size() - base, 0);
    check_val("midrst.m66_kept", 32'(mem[66]), 32'h5A);
    check_val("midrst.m67_kept", 32'(mem[67]), 32'hA5);
    p0 = model_prod(0);
    check_val("midrst.pair0_msw", 32'(mem[64]), p0 >> DW);
    check_val("midrst.pair0_lsw", 32'(mem[65]), p0 & ((1 << DW) - 1));
    run_pairs("postrst", 3, -1);

`ifdef PROD_SIGNED_EN
    // Signed operands: -1 * 2 and -128 * -128.
    smode = 1'b1;
    init_mem = mem;
    init_mem[0] = 8'hFF; init_mem[1] = 8'h02;
    init_mem[2] = 8'h80; init_mem[3] = 8'h80;
    load_mem();
    run_pairs("signed", 2, -1);
    check_val("signed.m64", 32'(mem[64]), 32'hFF);
    check_val("signed.m65", 32'(mem[65]), 32'hFE);
    check_val("signed.m66", 32'(mem[66]), 32'h40);
    check_val("signed.m67", 32'(mem[67]), 32'h00);
    smode = 1'b0;
`endif

    check_val("port_rules_violations", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
